// File: rtl/gate_vector_sequencer_pkg.sv
// gate_vector_sequencer_pkg
// Shared constants for the gate vector sequencer slice: FSM state
// encodings and the default sweep configuration.
// Build option: GATE_SEQ_STOP_ON_FAIL_EN (used by gate_vector_sequencer).
package gate_vector_sequencer_pkg;

  // FSM state encodings (2-bit, legacy-compatible values)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default sweep configuration
  localparam int DEF_WIDTH       = 2;
  localparam int DEF_HOLD_CYCLES = 4;

endpackage

// File: rtl/gate_hold_timer.sv
// gate_hold_timer
// 8-bit hold counter with synchronous clear and a terminal-count flag.
// tc is high while count == HOLD_CYCLES-1, i.e. on the last cycle of a
// hold window, which is where the sequencer samples the gate.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   clr   in  synchronous clear to zero (wins over en)
//   en    in  count enable
//   tc    out terminal-count flag
module gate_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(HOLD_CYCLES - 1);

  logic [7:0] count_r;

  // Hold counter: clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else if (en) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == TC_VAL);

endmodule

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer
// Synthesizable stimulus/response stage for a 2^WIDTH-row gate sweep.
// Drives every input vector in binary order, holds each for HOLD_CYCLES
// cycles, samples y_in on the last held cycle against &stim and counts
// mismatches. Reports done/pass/err_count at the end of the sweep.
// Build option: define GATE_SEQ_STOP_ON_FAIL_EN to end the run on the
// first mismatching sample (stim freezes on the failing vector).
// Ports:
//   clk       in  system clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   start     in  level; starts a run from IDLE or DONE
//   y_in      in  gate output under test
//   stim      out vector driven to the gate (bit 0 = A, bit 1 = B)
//   busy      out run in progress
//   done      out run finished, held until next start
//   pass      out valid with done; 1 when err_count == 0
//   err_count out mismatches in the current/last run (saturating)
//   mismatch  out one-cycle pulse the cycle after a failing sample
module gate_vector_sequencer
  import gate_vector_sequencer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ERR_W       = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_in,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             mismatch
);

  logic [1:0]       state_r, state_s;
  logic [WIDTH-1:0] stim_r, stim_s;
  logic [ERR_W-1:0] err_r, err_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic             mismatch_r, mismatch_s;
  logic             tc_s;
  logic             fail_s;
  logic             stop_s;
  logic             last_vec_s;

  // Timer is held at zero outside RUN and re-armed at every window end,
  // so each vector starts with a fresh count.
  gate_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state_r != ST_RUN) || tc_s),
    .en   (state_r == ST_RUN),
    .tc   (tc_s)
  );

  // y_in is only looked at on the last held cycle; earlier cycles are
  // the settle window for the gate.
  assign fail_s     = (state_r == ST_RUN) && tc_s && (y_in != (&stim_r));
  assign last_vec_s = (stim_r == {WIDTH{1'b1}});

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
  assign stop_s = fail_s;
`else
  assign stop_s = 1'b0;
`endif

  // Next-state logic for the FSM and all registered outputs.
  always_comb begin
    state_s    = state_r;
    stim_s     = stim_r;
    err_s      = err_r;
    busy_s     = busy_r;
    done_s     = done_r;
    pass_s     = pass_r;
    mismatch_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_RUN;
          stim_s  = {WIDTH{1'b0}};
          err_s   = {ERR_W{1'b0}};
          busy_s  = 1'b1;
          done_s  = 1'b0;
          pass_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (tc_s) begin
          if (fail_s) begin
            mismatch_s = 1'b1;
            if (err_r != {ERR_W{1'b1}}) begin
              err_s = err_r + ERR_W'(1);
            end else begin
              err_s = err_r;
            end
          end else begin
            err_s = err_r;
          end
          // Terminal vector (or early stop) ends the run; stim holds.
          if (last_vec_s || stop_s) begin
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (err_s == {ERR_W{1'b0}});
          end else begin
            stim_s = stim_r + WIDTH'(1);
          end
        end else begin
          stim_s = stim_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        stim_s  = {WIDTH{1'b0}};
        err_s   = {ERR_W{1'b0}};
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      stim_r     <= {WIDTH{1'b0}};
      err_r      <= {ERR_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      mismatch_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      stim_r     <= stim_s;
      err_r      <= err_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      pass_r     <= pass_s;
      mismatch_r <= mismatch_s;
    end
  end

  assign stim      = stim_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;
  assign mismatch  = mismatch_r;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb_gate_vector_sequencer
// Directed bench: models the gate under test (AND, stuck-0, OR, stuck-1)
// and checks the sweep timing, mismatch pulses and final report.
module tb_gate_vector_sequencer;

  localparam int WIDTH = 2;
  localparam int HOLD  = 4;
  localparam int ERR_W = WIDTH + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             y_in;
  logic [WIDTH-1:0] stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             mismatch;

  int total;
  int bad;
  int gate_mode;  // 0 AND, 1 stuck-0, 2 OR, 3 stuck-1

  int run_cycles;
  int pulses;
  int stim_bad;
  int vec_mask;

  gate_vector_sequencer #(
    .WIDTH      (WIDTH),
    .HOLD_CYCLES(HOLD),
    .ERR_W      (ERR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .y_in     (y_in),
    .stim     (stim),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test
  always_comb begin
    case (gate_mode)
      0: y_in = stim[0] & stim[1];
      1: y_in = 1'b0;
      2: y_in = stim[0] | stim[1];
      3: y_in = 1'b1;
      default: y_in = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Starts a run and follows it until done (bounded). Records RUN cycle
  // count, mismatch pulses, stim sequence errors, and a mask of vectors
  // whose sample failed (pulse at cycle k blames the vector of cycle k-1).
  task automatic do_run(input bit hold_start);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    run_cycles = 0;
    pulses     = 0;
    stim_bad   = 0;
    vec_mask   = 0;
    for (int k = 0; k < 200; k++) begin
      if (mismatch && k > 0) begin
        pulses++;
        vec_mask = vec_mask | (1 << ((k - 1) / HOLD));
      end
      if (done) break;
      if (busy) begin
        if (stim !== WIDTH'(k / HOLD)) stim_bad++;
        run_cycles++;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    gate_mode = 0;
    start     = 1'b0;
    rst_n     = 1'b0;
    #12;
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_mm", 32'(mismatch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: correct AND gate
    gate_mode = 0;
    do_run(1'b0);
    check("t1_cycles", 32'(run_cycles), 32'd16);
    check("t1_stim_seq", 32'(stim_bad), 32'd0);
    check("t1_pulses", 32'(pulses), 32'd0);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_err", 32'(err_count), 32'd0);
    check("t1_stim_hold", 32'(stim), 32'd3);

    // 2: stuck at 0, fails only on vector 11
    gate_mode = 1;
    do_run(1'b0);
    check("t2_cycles", 32'(run_cycles), 32'd16);
    check("t2_pulses", 32'(pulses), 32'd1);
    check("t2_vecs", 32'(vec_mask), 32'b1000);
    check("t2_err", 32'(err_count), 32'd1);
    check("t2_pass", 32'(pass), 32'd0);
    check("t2_done", 32'(done), 32'd1);

    // 3: OR gate, fails on vectors 01 and 10
    gate_mode = 2;
    do_run(1'b0);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    check("t3_cycles", 32'(run_cycles), 32'd8);
    check("t3_vecs", 32'(vec_mask), 32'b0010);
    check("t3_err", 32'(err_count), 32'd1);
    check("t3_stim", 32'(stim), 32'd1);
`else
    check("t3_cycles", 32'(run_cycles), 32'd16);
    check("t3_vecs", 32'(vec_mask), 32'b0110);
    check("t3_err", 32'(err_count), 32'd2);
    check("t3_stim", 32'(stim), 32'd3);
`endif
    check("t3_pass", 32'(pass), 32'd0);
    check("t3_done", 32'(done), 32'd1);

    // 4: start held through RUN is ignored; restart from DONE clears err
    gate_mode = 0;
    do_run(1'b1);
    check("t4_cycles", 32'(run_cycles), 32'd16);
    check("t4_stim_seq", 32'(stim_bad), 32'd0);
    check("t4_pass", 32'(pass), 32'd1);
    gate_mode = 1;
    do_run(1'b0);
    check("t4b_err", 32'(err_count), 32'd1);
    gate_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t4_restart_stim", 32'(stim), 32'd0);
    check("t4_restart_err", 32'(err_count), 32'd0);
    check("t4_restart_busy", 32'(busy), 32'd1);
    check("t4_restart_done", 32'(done), 32'd0);

    // 5: async reset mid-run on vector 10
    repeat (8) @(posedge clk);
    #1;
    check("t5_pre_stim", 32'(stim), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_stim", 32'(stim), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_err", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(1'b0);
    check("t5_cycles", 32'(run_cycles), 32'd16);
    check("t5_stim_seq", 32'(stim_bad), 32'd0);
    check("t5_pass", 32'(pass), 32'd1);

    // 6: stuck at 1, fails on vectors 00, 01, 10
    gate_mode = 3;
    do_run(1'b0);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    check("t6_cycles", 32'(run_cycles), 32'd4);
    check("t6_vecs", 32'(vec_mask), 32'b0001);
    check("t6_err", 32'(err_count), 32'd1);
    check("t6_stim", 32'(stim), 32'd0);
`else
    check("t6_cycles", 32'(run_cycles), 32'd16);
    check("t6_vecs", 32'(vec_mask), 32'b0111);
    check("t6_err", 32'(err_count), 32'd3);
    check("t6_stim", 32'(stim), 32'd3);
`endif
    check("t6_pass", 32'(pass), 32'd0);
    check("t6_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
